// File: rtl/audio_mix_stage.sv
// audio_mix_stage: N-channel wet/dry mixer joining two Avalon-ST frame streams
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   dry_data     dry samples, channel 0 in the LSBs (signed DATA_W each)
//   dry_valid    dry frame valid
//   dry_ready    dry frame accepted (only together with the wet frame)
//   wet_data     wet samples, same packing as dry_data
//   wet_valid    wet frame valid
//   wet_ready    wet frame accepted (always equal to dry_ready)
//   out_data     mixed samples, same packing
//   out_valid    output frame valid
//   out_ready    downstream ready
//   mix_target   requested mix, 0 = dry, all-ones = full wet
//   mix_update   one-cycle strobe latching mix_target
//   bypass       force the frame's output to equal its dry input
//   mix_current  coefficient currently applied (full wet = 2^COEF_W)
module audio_mix_stage #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 24,
    parameter int COEF_W = 24,
    parameter int STEP   = 4096
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_CH*DATA_W-1:0]   dry_data,
    input  logic                     dry_valid,
    output logic                     dry_ready,
    input  logic [N_CH*DATA_W-1:0]   wet_data,
    input  logic                     wet_valid,
    output logic                     wet_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic [COEF_W-1:0]        mix_target,
    input  logic                     mix_update,
    input  logic                     bypass,
    output logic [COEF_W:0]          mix_current
);

    // Product width: (DATA_W+1)-bit difference times (COEF_W+1)-bit coefficient,
    // with headroom for the rounding constant.
    localparam int PW = DATA_W + COEF_W + 3;
    localparam int CW = COEF_W + 1;
    localparam logic [CW-1:0]        FULL   = CW'(1) << COEF_W;
    localparam logic [CW-1:0]        STEP_C = CW'(STEP);
    localparam logic signed [PW-1:0] HALF   = PW'(1) << (COEF_W - 1);

    logic                            adv;
    logic                            acc;
    logic [CW-1:0]                   target;
    logic [CW-1:0]                   tgt_next;
    logic [CW-1:0]                   step_up;
    logic [CW-1:0]                   step_dn;
    logic [CW-1:0]                   mix_next;
    logic                            s1_valid;
    logic                            s1_bypass;
    logic [N_CH*DATA_W-1:0]          s1_dry;
    logic [N_CH-1:0][PW-1:0]         s1_prod;
    logic [N_CH-1:0][PW-1:0]         prod;
    logic signed [PW-1:0]            d_x;
    logic signed [PW-1:0]            m_x;
    logic signed [PW-1:0]            r;
    logic [N_CH*DATA_W-1:0]          mixed;

    // The whole pipeline moves as one; ready is held low during reset.
    assign adv       = !out_valid || out_ready;
    assign acc       = reset_n && adv && dry_valid && wet_valid;
    assign dry_ready = acc;
    assign wet_ready = acc;

    // All-ones maps to exactly 2^COEF_W so full wet is reproduced bit-exactly.
    // The ramp aims at tgt_next so an update coinciding with a frame steps
    // toward the new target in that same cycle.
    always_comb begin
        tgt_next = mix_update ? ((&mix_target) ? FULL : {1'b0, mix_target}) : target;
        step_up  = (tgt_next - mix_current < STEP_C) ? tgt_next - mix_current : STEP_C;
        step_dn  = (mix_current - tgt_next < STEP_C) ? mix_current - tgt_next : STEP_C;
        mix_next = (mix_current < tgt_next) ? mix_current + step_up :
                   (mix_current > tgt_next) ? mix_current - step_dn : mix_current;
    end

    // Stage 1: (wet - dry) * m per channel, m zero-extended to stay unsigned.
    always_comb begin
        prod = '0;
        d_x  = '0;
        m_x  = PW'({1'b0, mix_current});
        for (int i = 0; i < N_CH; i++) begin
            d_x     = PW'($signed(wet_data[i*DATA_W +: DATA_W])) -
                      PW'($signed(dry_data[i*DATA_W +: DATA_W]));
            prod[i] = d_x * m_x;
        end
    end

    // Stage 2: round half up, scale back, add dry. The result lies between dry
    // and wet, so keeping the low DATA_W bits is exact.
    always_comb begin
        mixed = '0;
        r     = '0;
        for (int i = 0; i < N_CH; i++) begin
            r = ($signed(s1_prod[i]) + HALF) >>> COEF_W;
            r = r + PW'($signed(s1_dry[i*DATA_W +: DATA_W]));
            mixed[i*DATA_W +: DATA_W] = s1_bypass ? s1_dry[i*DATA_W +: DATA_W] : r[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target      <= '0;
            mix_current <= '0;
            s1_valid    <= 1'b0;
            s1_bypass   <= 1'b0;
            s1_dry      <= '0;
            s1_prod     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            target <= tgt_next;
            if (acc)
                mix_current <= mix_next;
            if (adv) begin
                s1_valid  <= acc;
                s1_bypass <= bypass;
                s1_dry    <= dry_data;
                s1_prod   <= prod;
                out_valid <= s1_valid;
                out_data  <= mixed;
            end
        end
    end

endmodule

// File: tb/tb_audio_mix_stage.sv
// tb_audio_mix_stage: randomized and directed checks of audio_mix_stage against a frame-level model
module tb_audio_mix_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [47:0] dry_data;
    logic        dry_valid;
    logic        dry_ready;
    logic [47:0] wet_data;
    logic        wet_valid;
    logic        wet_ready;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] mix_target;
    logic        mix_update;
    logic        bypass;
    logic [24:0] mix_current;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    longint      cur = 0;
    longint      tgt = 0;
    logic [47:0] q[$];
    int          qc[$];
    bit          stall = 0;
    logic [47:0] held = '0;

    audio_mix_stage #(.N_CH(2), .DATA_W(24), .COEF_W(24), .STEP(4096)) dut (
        .clk(clk), .reset_n(reset_n),
        .dry_data(dry_data), .dry_valid(dry_valid), .dry_ready(dry_ready),
        .wet_data(wet_data), .wet_valid(wet_valid), .wet_ready(wet_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .mix_target(mix_target), .mix_update(mix_update), .bypass(bypass),
        .mix_current(mix_current)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frame result: dry + round((wet - dry) * m / 2^24), or dry when bypassed.
    function automatic logic [47:0] mixf(logic [47:0] dr, logic [47:0] wt, longint m, bit byp);
        logic [47:0] res;
        longint d, w, v;
        res = '0;
        for (int c = 0; c < 2; c++) begin
            d = longint'($signed(dr[c*24 +: 24]));
            w = longint'($signed(wt[c*24 +: 24]));
            v = byp ? d : d + ((((w - d) * m) + 64'sd8388608) >>> 24);
            res[c*24 +: 24] = v[23:0];
        end
        return res;
    endfunction

    function automatic longint ramp(longint c, longint t);
        if (c < t) return c + ((t - c < 4096) ? t - c : 4096);
        if (c > t) return c - ((c - t < 4096) ? c - t : 4096);
        return c;
    endfunction

    // One clock cycle: inputs were set at the preceding negedge.
    task automatic step();
        logic rdy;
        logic exp_ov;
        #1;
        if (!reset_n) begin
            q.delete();
            qc.delete();
            cur = 0;
            tgt = 0;
            stall = 0;
        end
        rdy    = reset_n && dry_valid && wet_valid && (!out_valid || out_ready);
        exp_ov = (q.size() > 0) && (cyc - qc[0] >= 2);
        chk("dry_ready", dry_ready, rdy);
        chk("wet_ready", wet_ready, rdy);
        chk("mix_current", mix_current, cur);
        chk("out_valid", out_valid, exp_ov);
        if (stall) chk("stall_hold", out_data, held);
        if (out_valid && q.size() > 0) chk("out_data", out_data, q[0]);
        stall = out_valid && !out_ready;
        held  = out_data;
        if (out_valid && out_ready && q.size() > 0) begin
            void'(q.pop_front());
            void'(qc.pop_front());
        end
        if (reset_n) begin
            if (mix_update) tgt = (mix_target == 24'hFFFFFF) ? 64'h1000000 : longint'(mix_target);
            if (rdy) begin
                q.push_back(mixf(dry_data, wet_data, cur, bypass));
                qc.push_back(cyc);
                cur = ramp(cur, tgt);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        mix_update = 1'b0;
    endtask

    task automatic send(input logic [47:0] d, input logic [47:0] w);
        dry_data  = d;
        wet_data  = w;
        dry_valid = 1'b1;
        wet_valid = 1'b1;
        step();
        dry_valid = 1'b0;
        wet_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        dry_valid = 1'b0;
        wet_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rnd(input int n, input bit full, input bit upd);
        for (int i = 0; i < n; i++) begin
            dry_data  = 48'({$urandom(), $urandom()});
            wet_data  = 48'({$urandom(), $urandom()});
            dry_valid = full || ($urandom_range(0, 3) != 0);
            wet_valid = full || ($urandom_range(0, 3) != 0);
            out_ready = full || ($urandom_range(0, 3) != 0);
            bypass    = !full && ($urandom_range(0, 4) == 0);
            if (upd && $urandom_range(0, 19) == 0) begin
                mix_target = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom());
                mix_update = 1'b1;
            end
            step();
        end
        bypass = 1'b0;
    endtask

    task automatic set_target(input logic [23:0] t);
        mix_target = t;
        mix_update = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        dry_data = '0; wet_data = '0;
        dry_valid = 1'b1; wet_valid = 1'b1;
        out_ready = 1'b1; mix_target = '0; mix_update = 1'b0; bypass = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_dry_ready", dry_ready, 0);
        chk("rst_wet_ready", wet_ready, 0);
        chk("rst_mix", mix_current, 0);
        @(negedge clk);
        dry_valid = 1'b0; wet_valid = 1'b0;
        reset_n = 1'b1;
        idle(2);

        // Full dry with 2-cycle latency and a single output pulse.
        send({24'(-1000), 24'(1000)}, {24'(5000), 24'(5000)});
        chk("lat_s1", out_valid, 0);
        step();
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_data", out_data, {24'(-1000), 24'(1000)});
        step();
        chk("single_pulse", out_valid, 0);

        // Ramp 0 -> 0x2000, retarget to 0x800 on the second frame.
        set_target(24'h002000);
        step();
        send({24'h0, 24'h0}, {24'h100000, 24'h100000});
        chk("ramp1", mix_current, 25'h1000);
        set_target(24'h000800);
        send({24'h0, 24'h0}, {24'h100000, 24'h100000});
        chk("ramp2", mix_current, 25'h0800);
        chk("ramp_f1", out_data, 48'h0);
        step();
        chk("ramp_f2", out_data, {24'd256, 24'd256});
        idle(3);

        // Backpressure with wet_valid toggling.
        out_ready = 1'b1;
        rnd(3, 1'b1, 1'b0);
        out_ready = 1'b0;
        dry_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wet_valid = i[0];
            dry_data  = 48'({$urandom(), $urandom()});
            wet_data  = 48'({$urandom(), $urandom()});
            step();
        end
        idle(4);

        rnd(1500, 1'b0, 1'b1);
        idle(4);

        // Ramp to exact full wet.
        set_target(24'hFFFFFF);
        rnd(4200, 1'b1, 1'b0);
        idle(4);
        chk("full_mix", mix_current, 25'h1000000);
        send({24'h100000, 24'h100000}, {24'h700000, 24'h700000});
        step();
        chk("full_wet", out_data, {24'h700000, 24'h700000});
        idle(2);

        // Half mix rounding.
        set_target(24'h800000);
        rnd(2100, 1'b1, 1'b0);
        idle(4);
        chk("half_mix", mix_current, 25'h0800000);
        send(48'h0, {24'hFFFFFC, 24'hFFFFFC});
        send(48'h0, {24'd3, 24'd3});
        chk("half_neg", out_data, {24'hFFFFFE, 24'hFFFFFE});
        step();
        chk("half_pos", out_data, {24'd2, 24'd2});
        idle(2);

        // Reset mid-stream.
        rnd(30, 1'b0, 1'b1);
        reset_n = 1'b0;
        dry_valid = 1'b0; wet_valid = 1'b0; mix_update = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_mix", mix_current, 0);
        idle(2);
        reset_n = 1'b1;
        idle(2);
        send({24'h123456, 24'h654321}, {24'h7FFFFF, 24'h800000});
        step();
        chk("post_rst_dry", out_data, {24'h123456, 24'h654321});
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/audio_mix_stage.md
Name: audio_mix_stage

Overview:
Parametrised N-channel wet/dry mixer on Avalon-ST audio streams. It sits between the reverb core output and the audio controller sink. It joins a dry frame and a wet frame, blends them per channel with a mix coefficient, and drives one output frame. The mix coefficient ramps linearly toward a new target on each parameter update, so mix changes from the PIO do not produce zipper noise.

Parameters:
N_CH, 2, number of audio channels per frame
DATA_W, 24, signed two's-complement sample width
COEF_W, 24, mix coefficient width; full wet = 2^COEF_W
STEP, 4096, coefficient change per accepted frame while ramping (1..2^COEF_W)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
dry_data  in  N_CH*DATA_W  dry samples, channel 0 in LSBs
dry_valid  in  1  dry frame valid
dry_ready  out  1  dry frame accepted
wet_data  in  N_CH*DATA_W  wet samples, same packing
wet_valid  in  1  wet frame valid
wet_ready  out  1  wet frame accepted
out_data  out  N_CH*DATA_W  mixed samples
out_valid  out  1  output frame valid
out_ready  in  1  downstream ready
mix_target  in  COEF_W  requested mix (0 = dry, all-ones = full wet)
mix_update  in  1  one-cycle strobe that latches mix_target
bypass  in  1  force output = dry
mix_current  out  COEF_W+1  coefficient currently applied

Behaviour:
- One clock; reset is asynchronous and active-low. All state clears on assertion.
- Reset values:
  - out_valid = 0, out_data = 0, dry_ready = wet_ready = 0.
  - mix_current = 0 and target = 0 (full dry).
  - Pipeline valids = 0.
- Reset mid-operation discards in-flight frames. No output is produced for them.
- Join handshake:
  - adv = !out_valid || out_ready.
  - dry_ready = wet_ready = adv & dry_valid & wet_valid.
  - A frame is accepted only when both streams are valid. A lone valid stream is held without transfer.
- Pipeline: 2 stages, latency 2 cycles from acceptance to out_valid. Full throughput of 1 frame/cycle while out_ready = 1.
  - Stall: when adv = 0, all stages hold and out_data/out_valid are stable.
  - Stage 1 per channel: d = wet - dry as a (DATA_W+1)-bit signed value; p = d * m as signed, where m is unsigned COEF_W+1 bits.
  - Stage 2: out = dry + ((p + 2^(COEF_W-1)) >>> COEF_W).
  - The result always lies between dry and wet, so no saturation is needed. The DATA_W truncation is exact.
- Coefficient mapping:
  - mix_target = 2^COEF_W - 1 latches as target 2^COEF_W, giving exact wet.
  - Any other value latches unchanged.
  - m = 0 gives exact dry; m = 2^COEF_W gives exact wet.
- Bypass: sampled at acceptance and carried with the frame. When set, the frame's output equals dry exactly. Ramping continues regardless.
- Ramp, updated once per accepted frame after that frame captures m:
  - current < target: current += min(STEP, target - current).
  - current > target: current -= min(STEP, current - target).
  - Equal: hold.
  - No updates occur without accepted frames.
- mix_update:
  - Latches the new target the same cycle.
  - Mid-ramp: the ramp continues from the present current toward the new target, with no jump.
  - Simultaneous with a frame acceptance: that frame uses the old current, and that cycle's ramp step moves toward the new target.
- mix_current reflects the registered current; it is updated the cycle after each accepted frame.

Test Plan:
- Reset, then mix at 0, N_CH = 2. Dry = {+1000, -1000}, wet = {+5000, +5000} → out = {+1000, -1000} 2 cycles after acceptance, out_valid pulses once.
- mix_target = 0xFFFFFF with STEP = 2^24, update, send 1 frame, then dry = 0x100000, wet = 0x700000 → second frame out = 0x700000, mix_current = 0x1000000.
- Target 0x800000 reached, dry = 0, wet = -4 → out = -2. With wet = 3 → out = 2 (round-half-up check).
- STEP = 4096, target 0 → 0x002000 → mix_current reads 0x1000 after the 1st frame and 0x2000 after the 2nd. A new target 0x000800 issued on the 2nd frame's acceptance cycle → 2nd frame uses 0x1000, mix_current then 0x0800.
- out_ready low for 5 cycles with 3 frames in flight, wet_valid toggling → out_data stable, no frame lost or duplicated, dry_ready never high while wet_valid = 0. Sequence order is preserved.
- Assert reset_n low mid-stream → out_valid = 0 and mix_current = 0 immediately. The first post-reset output is a fresh frame at full dry.
